i2s_frame_scheduler: RTL and testbench
======================================

Name: i2s_frame_scheduler

Overview:
- Sits in the i_mclk (24.576 MHz) domain between the 8 MHz AD sample holder and the I2S encoder.
- Synchronises the AD latch, buffers captured L/R sample pairs in a small FIFO, and releases exactly one pair per I2S frame on a fixed frame grid.
- Sequences playback through MUTE/PREFILL/RUN states, measures the source sample period for lock detection, and applies DIP-controlled mute and channel swap.

Parameters:
FRAME_LEN, 512, i_mclk cycles per I2S frame (48 kHz at 24.576 MHz)
FIFO_DEPTH, 4, sample-pair FIFO entries (power of two)
PREFILL, 2, FIFO level needed to leave PREFILL
TIMEOUT, 4096, i_mclk cycles without a latch before forcing MUTE
LOCK_TOL, 8, max cycle difference between consecutive periods still counted as stable
LOCK_COUNT, 4, consecutive stable periods required to assert o_locked

Ports:
i_mclk  in  1  sole clock
i_rst  in  1  asynchronous reset, active-high
i_latch  in  1  AD latch (asynchronous to i_mclk); rising edge = new pair held stable on i_data_l/r
i_data_l  in  16  left sample from holder
i_data_r  in  16  right sample from holder
i_dip  in  2  [0] force mute, [1] swap L/R (synchronised internally)
i_clr_status  in  1  one-cycle pulse clears sticky flags
o_load  out  1  one-cycle strobe: encoder captures o_data_l/r
o_data_l  out  16  left word to encoder
o_data_r  out  16  right word to encoder
o_state  out  2  0 MUTE, 1 PREFILL, 2 RUN
o_locked  out  1  source period stable
o_period  out  16  last measured latch-to-latch period in i_mclk cycles
o_underrun  out  1  sticky: frame boundary hit with an empty FIFO in RUN
o_overrun  out  1  sticky: new sample arrived with the FIFO full

Behaviour:
- Reset: all outputs 0, state MUTE, FIFO empty, frame counter 0, lock counter 0.
- Latch sync: 3-flop synchroniser on i_latch (same for i_dip). Edge = sync2 & ~sync3; i_data_l/r are sampled on the edge cycle (holder keeps them stable for the full source period). Capture latency from latch edge to FIFO write ≤ 4 cycles.
- Frame grid: free-running counter 0..FRAME_LEN-1 that wraps. Frame boundary is count == FRAME_LEN-1.
- o_load: pulses on the cycle after each boundary, in every state. o_data_l/r are updated on that same cycle.
- Output data by state:
  - MUTE or PREFILL: zeros.
  - RUN with FIFO non-empty: pop one pair.
  - RUN with FIFO empty: repeat the last output pair and set o_underrun.
- i_dip[0]=1 forces zeros on o_data_l/r, but the FIFO is still popped. i_dip[1]=1 swaps L and R at output.
- FIFO write: push on each latch edge. When full, the incoming pair is dropped, the FIFO contents are unchanged, and o_overrun is set. Push and pop in the same cycle with the FIFO full is not an overrun; the level is unchanged.
- State transitions:
  - MUTE -> PREFILL on the first latch edge.
  - PREFILL -> RUN at a frame boundary when level ≥ PREFILL.
  - RUN -> PREFILL after 2 consecutive underrun frames.
  - Any state -> MUTE when the timeout counter reaches TIMEOUT. The FIFO is flushed in the same cycle and o_locked is cleared.
- Timeout counter: cleared on every latch edge, saturates at TIMEOUT.
- Period measurement:
  - 16-bit counter cleared on each latch edge, saturating at 0xFFFF. o_period is loaded with the count on each edge.
  - A period is stable if |new − previous| ≤ LOCK_TOL; each stable period increments the lock counter, saturating at LOCK_COUNT. An unstable period resets the lock counter to 0.
  - o_locked = (lock counter == LOCK_COUNT).
- Sticky flags: i_clr_status clears them. If a set and a clear occur in the same cycle, set wins.
- Simultaneous latch edge and timeout: the latch edge wins (timeout counter is cleared, no MUTE).

Decomposition:
- Shared package: state encoding (MUTE/PREFILL/RUN), default FRAME_LEN/TIMEOUT constants, sample-pair struct (16-bit L, 16-bit R).
- One sub-module: sample_pair_fifo, a synchronous FIFO of FIFO_DEPTH × 32 bits with push/pop/flush, full/empty and level outputs.
- Synchroniser, frame counter, period/lock logic and FSM stay in the top module.

Test Plan:
- Reset release with no latch, 3 frames -> o_load every 512 cycles, o_data=0, o_state=0, all flags 0.
- Latch every 512 cycles with L=0x1234, R=0xABCD -> PREFILL, then RUN at the boundary after level reaches 2. Output 0x1234/0xABCD; o_period=512; o_locked=1 after the 4th stable period.
- Same stream with i_dip=2'b10 -> o_data_l=0xABCD, o_data_r=0x1234. With i_dip=2'b01 -> zeros while still in RUN and the FIFO keeps draining.
- Latch period 520 (source slower than the frame grid) -> an underrun eventually occurs: last pair repeated, o_underrun=1. Two consecutive empty boundaries -> o_state=1. Pulse i_clr_status -> o_underrun=0.
- Latch period 500 for ≥ 200 frames -> FIFO fills, o_overrun=1, no FIFO corruption (output sequence monotonic with a counting pattern).
- Stop latches mid-RUN -> exactly 4096 cycles after the last edge: o_state=0, FIFO flushed, o_locked=0. Then assert i_rst mid-frame -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/i2s_frame_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// i2s_frame_scheduler_pkg
// Shared types and defaults for the I2S frame scheduler slice.
//   state_t        playback sequencer states (encoding is visible on o_state)
//   sample_pair_t  one captured left/right sample pair
//   apply_dip()    output-side mute/swap applied to a pair
// -----------------------------------------------------------------------------
package i2s_frame_scheduler_pkg;

  localparam int FRAME_LEN_DEF = 512;   // 48 kHz frames at 24.576 MHz
  localparam int TIMEOUT_DEF   = 4096;  // mclk cycles of silence before muting

  typedef enum logic [1:0] {
    ST_MUTE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } sample_pair_t;

  // Mute wins over swap: a muted pair is all zeros regardless of ordering.
  function automatic sample_pair_t apply_dip(sample_pair_t pair, logic mute, logic swap);
    sample_pair_t res;
    res = pair;
    if (swap) begin
      res.l = pair.r;
      res.r = pair.l;
    end
    if (mute) res = '0;
    return res;
  endfunction

endpackage

// File: rtl/i2s_frame_scheduler_sample_pair_fifo.sv
// -----------------------------------------------------------------------------
// sample_pair_fifo
// Synchronous FIFO of DEPTH x 32-bit sample pairs with first-word fall-through
// read data. A push while full is accepted only if a pop happens in the same
// cycle; a pop while empty is ignored. flush empties the FIFO and wins over
// push/pop.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, wr_data     write request and data
//   pop               read request; rd_data is the current head
//   flush             discard all entries
//   full, empty       status
//   level             number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sample_pair_fifo #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [31:0]   wr_data,
  input  logic          pop,
  input  logic          flush,
  output logic [31:0]   rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, so clearing them would add reset fan-out for no benefit.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/i2s_frame_scheduler.sv
// -----------------------------------------------------------------------------
// i2s_frame_scheduler
// Bridges the AD sample holder to the I2S encoder in the i_mclk domain.
// Captured L/R pairs are buffered and released one per frame on a free-running
// FRAME_LEN grid, sequenced through MUTE/PREFILL/RUN, with source period
// measurement for lock detection and DIP-controlled mute / channel swap.
// Ports:
//   i_mclk, i_rst       clock, asynchronous active-high reset
//   i_latch             async AD latch; rising edge = new pair on i_data_l/r
//   i_data_l, i_data_r  sample pair from the holder
//   i_dip               [0] force mute, [1] swap L/R (async, synchronised)
//   i_clr_status        one-cycle pulse clearing the sticky flags
//   o_load              strobe on the cycle after each frame boundary
//   o_data_l, o_data_r  words to the encoder, updated together with o_load
//   o_state             0 MUTE, 1 PREFILL, 2 RUN
//   o_locked            source period stable for LOCK_COUNT periods
//   o_period            last latch-to-latch period in i_mclk cycles
//   o_underrun          sticky: RUN boundary found the FIFO empty
//   o_overrun           sticky: a pair was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module i2s_frame_scheduler
  import i2s_frame_scheduler_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int PREFILL    = 2,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int LOCK_TOL   = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic        i_mclk,
  input  logic        i_rst,
  input  logic        i_latch,
  input  logic [15:0] i_data_l,
  input  logic [15:0] i_data_r,
  input  logic [1:0]  i_dip,
  input  logic        i_clr_status,
  output logic        o_load,
  output logic [15:0] o_data_l,
  output logic [15:0] o_data_r,
  output logic [1:0]  o_state,
  output logic        o_locked,
  output logic [15:0] o_period,
  output logic        o_underrun,
  output logic        o_overrun
);

  localparam int FW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TOUT_MAX    = TW'(TIMEOUT);
  localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_COUNT);
  localparam logic [AW:0]   PREFILL_LVL = (AW+1)'(PREFILL);
  localparam logic [15:0]   TOL         = 16'(LOCK_TOL);

  // ---------------------------------------------------------------------------
  // Input synchronisers (3 flops; the third stage gives the latch edge detect)
  // ---------------------------------------------------------------------------
  logic [2:0] latch_sync;
  logic [1:0] dip_s1, dip_s2, dip_s3;
  logic       latch_edge;

  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      latch_sync <= '0;
      dip_s1     <= '0;
      dip_s2     <= '0;
      dip_s3     <= '0;
    end else begin
      latch_sync <= {latch_sync[1:0], i_latch};
      dip_s1     <= i_dip;
      dip_s2     <= dip_s1;
      dip_s3     <= dip_s2;
    end
  end

  // The holder keeps i_data_l/r stable for a whole source period, so sampling
  // them directly on the edge cycle is safe.
  assign latch_edge = latch_sync[1] & ~latch_sync[2];

  // ---------------------------------------------------------------------------
  // Frame grid
  // ---------------------------------------------------------------------------
  logic [FW-1:0] frame_cnt;
  logic          boundary;

  assign boundary = (frame_cnt == FRAME_LAST);

  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst)         frame_cnt <= '0;
    else if (boundary) frame_cnt <= '0;
    else               frame_cnt <= frame_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Source timeout: a latch edge always beats an expiring timeout
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tout_cnt;
  logic          timeout_hit;

  assign timeout_hit = (tout_cnt == TOUT_MAX) && !latch_edge;

  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst)                    tout_cnt <= '0;
    else if (latch_edge)          tout_cnt <= '0;
    else if (tout_cnt != TOUT_MAX) tout_cnt <= tout_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Period measurement and lock detection
  // ---------------------------------------------------------------------------
  logic [15:0]   period_cnt;
  logic [15:0]   period_diff;
  logic          period_stable;
  logic [LW-1:0] lock_cnt;

  assign period_diff   = (period_cnt >= o_period) ? (period_cnt - o_period)
                                                  : (o_period - period_cnt);
  assign period_stable = (period_diff <= TOL);
  assign o_locked      = (lock_cnt == LOCK_MAX);

  // The counter restarts at 1 so that the edge cycle itself is counted and a
  // latch every N cycles reads back as exactly N.
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      period_cnt <= '0;
      o_period   <= '0;
      lock_cnt   <= '0;
    end else begin
      if (latch_edge) begin
        period_cnt <= 16'd1;
        o_period   <= period_cnt;
        if (!period_stable)        lock_cnt <= '0;
        else if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
      end else begin
        if (period_cnt != 16'hFFFF) period_cnt <= period_cnt + 1'b1;
        if (timeout_hit)            lock_cnt   <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  state_t       state, state_next;
  sample_pair_t wr_pair;
  sample_pair_t head_pair;
  logic [31:0]  fifo_rd;
  logic         fifo_full;
  logic         fifo_empty;
  logic [AW:0]  fifo_level;
  logic         pop_req;

  assign wr_pair   = '{l: i_data_l, r: i_data_r};
  assign head_pair = sample_pair_t'(fifo_rd);
  assign pop_req   = boundary && (state == ST_RUN) && !fifo_empty;

  sample_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (i_mclk),
    .rst     (i_rst),
    .push    (latch_edge),
    .wr_data (wr_pair),
    .pop     (pop_req),
    .flush   (timeout_hit),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // ---------------------------------------------------------------------------
  // Playback sequencer
  // ---------------------------------------------------------------------------
  logic underrun_set;
  logic overrun_set;
  logic prev_underrun;   // previous RUN boundary also found the FIFO empty

  assign underrun_set = boundary && (state == ST_RUN) && fifo_empty;
  // A full FIFO that is popped in the same cycle still accepts the new pair.
  assign overrun_set  = latch_edge && fifo_full && !pop_req;

  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) state <= ST_MUTE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_MUTE:    if (latch_edge) state_next = ST_PREFILL;
      ST_PREFILL: if (boundary && fifo_level >= PREFILL_LVL) state_next = ST_RUN;
      ST_RUN:     if (underrun_set && prev_underrun) state_next = ST_PREFILL;
      default:    state_next = ST_MUTE;
    endcase
    if (timeout_hit) state_next = ST_MUTE;
  end

  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst)                     prev_underrun <= 1'b0;
    else if (state_next != ST_RUN) prev_underrun <= 1'b0;
    else if (boundary && state == ST_RUN) prev_underrun <= fifo_empty;
  end

  assign o_state = state;

  // ---------------------------------------------------------------------------
  // Output words, load strobe and sticky flags
  // ---------------------------------------------------------------------------
  sample_pair_t last_pair;   // raw pair most recently sent (pre mute/swap)
  sample_pair_t pick_pair;
  sample_pair_t out_pair;

  // Outside RUN the encoder gets silence, and the repeat pair is cleared too.
  assign pick_pair = (state != ST_RUN) ? '0 : (fifo_empty ? last_pair : head_pair);
  assign out_pair  = apply_dip(pick_pair, dip_s3[0], dip_s3[1]);

  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      o_load     <= 1'b0;
      o_data_l   <= '0;
      o_data_r   <= '0;
      last_pair  <= '0;
      o_underrun <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_load <= boundary;
      if (boundary) begin
        last_pair <= pick_pair;
        o_data_l  <= out_pair.l;
        o_data_r  <= out_pair.r;
      end
      o_underrun <= underrun_set | (o_underrun & ~i_clr_status);
      o_overrun  <= overrun_set  | (o_overrun  & ~i_clr_status);
    end
  end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_i2s_frame_scheduler
// Randomised bench for i2s_frame_scheduler. A transaction-level reference
// model (sample queue, per-posedge event timestamps, frame arithmetic) predicts
// the load strobe, state, output words, period, lock and sticky flags.
// -----------------------------------------------------------------------------
module tb_i2s_frame_scheduler;

  localparam int FRAME = 512;
  localparam int DEPTH = 4;
  localparam int PREF  = 2;
  localparam int TOUT  = 4096;
  localparam int TOL   = 8;
  localparam int LOCKN = 4;

  localparam int M_MUTE = 0;
  localparam int M_PREF = 1;
  localparam int M_RUN  = 2;

  logic        i_mclk;
  logic        i_rst;
  logic        i_latch;
  logic [15:0] i_data_l;
  logic [15:0] i_data_r;
  logic [1:0]  i_dip;
  logic        i_clr_status;
  logic        o_load;
  logic [15:0] o_data_l;
  logic [15:0] o_data_r;
  logic [1:0]  o_state;
  logic        o_locked;
  logic [15:0] o_period;
  logic        o_underrun;
  logic        o_overrun;

  i2s_frame_scheduler dut (
    .i_mclk       (i_mclk),
    .i_rst        (i_rst),
    .i_latch      (i_latch),
    .i_data_l     (i_data_l),
    .i_data_r     (i_data_r),
    .i_dip        (i_dip),
    .i_clr_status (i_clr_status),
    .o_load       (o_load),
    .o_data_l     (o_data_l),
    .o_data_r     (o_data_r),
    .o_state      (o_state),
    .o_locked     (o_locked),
    .o_period     (o_period),
    .o_underrun   (o_underrun),
    .o_overrun    (o_overrun)
  );

  initial i_mclk = 1'b0;
  always #5 i_mclk = ~i_mclk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. cyc numbers posedges since reset release; a latch raised
  // just after posedge n takes effect (push, period, state) at posedge n+3.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  typedef struct {
    int          due;
    logic [15:0] l;
    logic [15:0] r;
  } due_t;

  due_t  due_q[$];
  pair_t m_q[$];
  pair_t m_last;
  int    cyc;
  int    m_state;
  int    m_uc;
  int    m_lock;
  int    m_period;
  int    m_last_edge;
  int    m_period_base;
  logic  m_load;
  logic  m_edge;
  logic  m_under;
  logic  m_over;
  logic [15:0] m_out_l;
  logic [15:0] m_out_r;
  logic [1:0]  m_dip;

  task automatic model_reset();
    cyc           = 0;
    m_state       = M_MUTE;
    m_uc          = 0;
    m_lock        = 0;
    m_period      = 0;
    m_last_edge   = 0;
    m_period_base = 1;
    m_load        = 1'b0;
    m_edge        = 1'b0;
    m_under       = 1'b0;
    m_over        = 1'b0;
    m_out_l       = '0;
    m_out_r       = '0;
    m_last        = '0;
    m_q.delete();
    due_q.delete();
  endtask

  task automatic model_step();
    int    p;
    int    nst;
    int    newp;
    int    diff;
    bit    is_bnd;
    bit    tout;
    bit    set_u;
    bit    set_o;
    due_t  ev;
    pair_t sel;
    cyc++;
    p      = cyc;
    m_edge = 1'b0;
    if (due_q.size() > 0 && due_q[0].due == p) begin
      m_edge = 1'b1;
      ev = due_q.pop_front();
    end
    is_bnd = (p % FRAME) == 0;
    tout   = !m_edge && (p - 1 - m_last_edge >= TOUT);
    nst    = m_state;
    set_u  = 1'b0;
    set_o  = 1'b0;
    m_load = is_bnd;
    if (is_bnd) begin
      if (m_state == M_RUN) begin
        if (m_q.size() > 0) begin
          m_last = m_q.pop_front();
          m_uc   = 0;
        end else begin
          set_u = 1'b1;
          m_uc++;
          if (m_uc == 2) nst = M_PREF;
        end
      end else begin
        m_last = '0;
        if (m_state == M_PREF && m_q.size() >= PREF) nst = M_RUN;
      end
      sel = m_last;
      if (m_dip[1]) sel = {m_last.r, m_last.l};
      if (m_dip[0]) sel = '0;
      m_out_l = sel.l;
      m_out_r = sel.r;
    end
    if (m_edge) begin
      newp = p - m_period_base;
      if (newp > 65535) newp = 65535;
      diff = (newp > m_period) ? newp - m_period : m_period - newp;
      if (diff <= TOL) m_lock = (m_lock < LOCKN) ? m_lock + 1 : LOCKN;
      else             m_lock = 0;
      m_period      = newp;
      m_period_base = p;
      m_last_edge   = p;
      if (m_q.size() < DEPTH) m_q.push_back({ev.l, ev.r});
      else                    set_o = 1'b1;
      if (m_state == M_MUTE) nst = M_PREF;
    end
    if (tout) begin
      nst = M_MUTE;
      m_q.delete();
      m_lock = 0;
    end
    if (nst != M_RUN) m_uc = 0;
    m_state = nst;
    m_under = set_u | (m_under & !i_clr_status);
    m_over  = set_o | (m_over  & !i_clr_status);
  endtask

  always @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) model_reset();
    else       model_step();
  end

  // ---------------------------------------------------------------------------
  // Continuous comparison, away from the active edge
  // ---------------------------------------------------------------------------
  bit chk_en = 1'b0;

  always @(negedge i_mclk) begin
    if (chk_en && !i_rst) begin
      check("load", 32'(o_load), 32'(m_load));
      check("state", 32'(o_state), 32'(m_state));
      if (m_load) begin
        check("data_l", 32'(o_data_l), 32'(m_out_l));
        check("data_r", 32'(o_data_r), 32'(m_out_r));
        check("underrun", 32'(o_underrun), 32'(m_under));
        check("overrun", 32'(o_overrun), 32'(m_over));
      end
      if (m_edge) begin
        check("period", 32'(o_period), 32'(m_period));
        check("locked", 32'(o_locked), 32'(m_lock == LOCKN));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: sample source driven one cycle at a time
  // ---------------------------------------------------------------------------
  bit          src_en    = 1'b0;
  int          src_mode  = 0;    // 0 fixed pattern, 1 random, 2 counting
  int          src_period = 512;
  int          src_jit   = 0;
  int          next_latch = 0;
  int          lat_hi    = 0;
  int          last_rise = 0;
  logic [15:0] count_val = '0;

  task automatic tick();
    logic [15:0] l;
    logic [15:0] r;
    @(posedge i_mclk);
    #1;
    if (lat_hi > 0) begin
      lat_hi--;
      if (lat_hi == 0) i_latch = 1'b0;
    end
    if (src_en && cyc >= next_latch) begin
      case (src_mode)
        0:       begin l = 16'h1234; r = 16'hABCD; end
        1:       begin l = 16'($urandom); r = 16'($urandom); end
        default: begin l = count_val; r = ~count_val; count_val = count_val + 16'd1; end
      endcase
      i_data_l = l;
      i_data_r = r;
      i_latch  = 1'b1;
      lat_hi   = 16;
      last_rise = cyc;
      due_q.push_back('{due: cyc + 3, l: l, r: r});
      next_latch = cyc + src_period + int'($urandom_range(src_jit, 0));
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic to_boundary();
    tick();
    while ((cyc % FRAME) != 0) tick();
  endtask

  task automatic set_dip(input logic [1:0] d);
    i_dip = d;
    m_dip = d;
  endtask

  task automatic pulse_clr();
    i_clr_status = 1'b1;
    tick();
    i_clr_status = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    i_rst        = 1'b1;
    i_latch      = 1'b0;
    i_data_l     = '0;
    i_data_r     = '0;
    i_dip        = '0;
    m_dip        = '0;
    i_clr_status = 1'b0;
    repeat (3) @(posedge i_mclk);
    @(negedge i_mclk);
    check("rst_load", 32'(o_load), 0);
    check("rst_state", 32'(o_state), 0);
    check("rst_period", 32'(o_period), 0);
    check("rst_flags", 32'({o_locked, o_underrun, o_overrun}), 0);
    i_rst  = 1'b0;
    chk_en = 1'b1;

    // Idle after reset: loads keep coming, silence, MUTE.
    run_cycles(3 * FRAME);
    check("idle_data", 32'({o_data_l, o_data_r}), 0);
    check("idle_state", 32'(o_state), M_MUTE);

    // Steady 512-cycle source with a fixed pair.
    src_en = 1'b1; src_mode = 0; src_period = 512; src_jit = 0;
    next_latch = cyc + 1;
    run_cycles(14 * FRAME);
    check("run_state", 32'(o_state), M_RUN);
    check("run_period", 32'(o_period), 512);
    check("run_locked", 32'(o_locked), 1);
    check("run_data", 32'({o_data_l, o_data_r}), 32'h1234ABCD);

    // Channel swap, then forced mute while RUN keeps draining.
    to_boundary();
    set_dip(2'b10);
    run_cycles(3 * FRAME);
    check("swap_data", 32'({o_data_l, o_data_r}), 32'hABCD1234);
    set_dip(2'b01);
    run_cycles(3 * FRAME);
    check("mute_data", 32'({o_data_l, o_data_r}), 0);
    check("mute_state", 32'(o_state), M_RUN);
    set_dip(2'b00);
    run_cycles(FRAME);

    // Slow source: underrun, then a gap for two empty frames -> PREFILL.
    src_mode = 1; src_period = 556; src_jit = 10;
    for (int i = 0; i < 40 * FRAME && !m_under; i++) tick();
    check("underrun_hit", 32'(o_underrun), 1);
    src_en = 1'b0;
    run_cycles(1600);
    check("underrun_prefill", 32'(o_state), M_PREF);
    pulse_clr();
    check("underrun_clr", 32'(o_underrun), 0);

    // Fast counting source: FIFO fills and overruns without corruption.
    src_en = 1'b1; src_mode = 2; src_period = 440; src_jit = 20;
    next_latch = cyc + 1;
    for (int i = 0; i < 60 * FRAME && !m_over; i++) tick();
    check("overrun_hit", 32'(o_overrun), 1);
    run_cycles(4 * FRAME);

    // Source stops: timeout forces MUTE, flushes and drops lock.
    src_en = 1'b0;
    target = last_rise + 3 + TOUT - 6;
    while (cyc < target) tick();
    check("pre_timeout_active", 32'(o_state != 2'd0), 1);
    target = last_rise + 3 + TOUT + 14;
    while (cyc < target) tick();
    check("timeout_state", 32'(o_state), M_MUTE);
    check("timeout_locked", 32'(o_locked), 0);

    // Restart with a jittered source; stale pairs must not reappear.
    src_en = 1'b1; src_mode = 1; src_period = 510; src_jit = 4;
    next_latch = cyc + 1;
    run_cycles(8 * FRAME);
    src_en = 1'b0;

    // Asynchronous reset mid-frame.
    tick();
    while ((cyc % FRAME) != 200) tick();
    chk_en = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_load", 32'(o_load), 0);
    check("arst_data", 32'({o_data_l, o_data_r}), 0);
    check("arst_state", 32'(o_state), 0);
    check("arst_period", 32'(o_period), 0);
    check("arst_flags", 32'({o_locked, o_underrun, o_overrun}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
